load_store_unit: RTL and testbench



---
 rtl/load_store_unit_pkg.sv | 17 +
 rtl/load_store_unit_if.sv | 32 +++
 rtl/load_store_unit_align.sv | 33 +++
 rtl/load_store_unit.sv | 101 ++++++++++
 tb/tb_load_store_unit.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// lsu_pkg: funct3 codes, FSM state type and request legality check shared by the load/store unit
package lsu_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} lsu_state_t;

    // High when funct3 is not a legal load/store encoding or the address is misaligned for its size
    function automatic logic bad_op(input logic we, input logic [2:0] f3, input logic [1:0] lo);
        return (we ? (f3[2] || f3 == 3'b011) : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111))
            || (f3[1:0] == F3_H[1:0] && lo[0])
            || (f3[1:0] == F3_W[1:0] && lo != 2'b00);
    endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: core request/response handshake plus word-wide data memory port
//   req_*  : core request (valid/ready), store flag, funct3, byte address, right-aligned store data
//   resp_* : response (valid/ready), extended load data, error flag
//   mem_*  : word address, write word, write/read enables, combinational read data
//   slave  : LSU view; master : core + memory view
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_write, mem_read
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_write, mem_read
    );
endinterface

// File: rtl/load_store_unit_align.sv
// lsu_align: byte/half extraction with extension for loads and byte/half merge for read-modify-write stores
//   funct3 : access size/sign; lane : addr[1:0]; word : memory word; wdata : right-aligned store data
//   load_data : extended load result; merged : word to write back
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);
    logic [4:0]  sh;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] bmask;

    always_comb begin
        sh        = {lane, 3'b000};
        b         = 8'(word >> sh);
        h         = lane[1] ? word[31:16] : word[15:0];
        bmask     = 32'h0000_00FF << sh;
        load_data = funct3 == F3_B  ? {{24{b[7]}}, b}
                  : funct3 == F3_BU ? {24'b0, b}
                  : funct3 == F3_H  ? {{16{h[15]}}, h}
                  : funct3 == F3_HU ? {16'b0, h}
                  : word;
        merged    = funct3[1:0] == F3_B[1:0] ? (word & ~bmask) | ({24'b0, wdata[7:0]} << sh)
                  : funct3[1:0] == F3_H[1:0] ? (lane[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]})
                  : wdata;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: turns RV32I byte/half/word loads and stores into word accesses, sub-word stores by read-modify-write
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : slave view of load_store_unit_if (core request/response and data memory port)
//   MEM_WORDS  : memory depth in words; byte addresses at or beyond MEM_WORDS*4 are errors
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 1024
) (
    input logic               clk,
    input logic               rst_n,
    load_store_unit_if.slave  bus
);
    lsu_state_t  state;
    logic        op_we;
    logic [2:0]  op_f3;
    logic [1:0]  op_lane;
    logic [31:0] op_wdata;
    logic [31:0] load_data;
    logic [31:0] merged;
    logic        req_err;

    assign req_err = bad_op(bus.req_we, bus.req_funct3, bus.req_addr[1:0])
                  || bus.req_addr >= 32'(MEM_WORDS) * 32'd4;

    lsu_align u_align (
        .funct3    (op_f3),
        .lane      (op_lane),
        .word      (bus.mem_rdata),
        .wdata     (op_wdata),
        .load_data (load_data),
        .merged    (merged)
    );

    // Memory controls are registered so they stay stable across the negedge write strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            op_we          <= 1'b0;
            op_f3          <= 3'b000;
            op_lane        <= 2'b00;
            op_wdata       <= 32'b0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= 32'b0;
            bus.mem_addr   <= 32'b0;
            bus.mem_wdata  <= 32'b0;
            bus.mem_write  <= 1'b0;
            bus.mem_read   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    op_we          <= bus.req_we;
                    op_f3          <= bus.req_funct3;
                    op_lane        <= bus.req_addr[1:0];
                    op_wdata       <= bus.req_wdata;
                    bus.req_ready  <= 1'b0;
                    bus.resp_rdata <= 32'b0;
                    bus.mem_addr   <= {bus.req_addr[31:2], 2'b00};
                    if (req_err) begin
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b1;
                        state          <= RESP;
                    end else if (!bus.req_we || bus.req_funct3[1:0] != F3_W[1:0]) begin
                        bus.mem_read <= 1'b1;
                        state        <= RD;
                    end else begin
                        bus.mem_wdata <= bus.req_wdata;
                        bus.mem_write <= 1'b1;
                        state         <= WR;
                    end
                end
                RD: begin
                    bus.mem_read <= 1'b0;
                    if (op_we) begin
                        bus.mem_wdata <= merged;
                        bus.mem_write <= 1'b1;
                        state         <= WR;
                    end else begin
                        bus.resp_rdata <= load_data;
                        bus.resp_valid <= 1'b1;
                        state          <= RESP;
                    end
                end
                WR: begin
                    bus.mem_write  <= 1'b0;
                    bus.resp_valid <= 1'b1;
                    state          <= RESP;
                end
                RESP: if (bus.resp_ready) begin
                    bus.resp_valid <= 1'b0;
                    bus.resp_err   <= 1'b0;
                    bus.req_ready  <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench with a word-array reference model and a negedge response monitor
module tb_load_store_unit;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
        int          nrd;
        int          nwr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    load_store_unit_if bus ();
    load_store_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    logic [31:0] mem [0:1023];
    logic [31:0] ref_mem [0:1023];
    exp_t q [$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.mem_rdata = mem[bus.mem_addr[11:2]];
    always @(negedge clk) if (bus.mem_write) mem[bus.mem_addr[11:2]] <= bus.mem_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: access size in bytes, legality sets, and shift/mask arithmetic over a word array
    function automatic exp_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        int sz;
        int sh;
        logic [31:0] m;
        logic [31:0] w;
        logic legal;
        sz = 1 << f3[1:0];
        sh = 8 * int'(addr % 4);
        m = sz >= 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 32'd1;
        legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        e.addr = addr;
        e.rdata = 32'b0;
        e.acc = 0;
        e.nrd = 0;
        e.nwr = 0;
        e.err = !legal || (addr % sz) != 0 || addr >= 32'd4096;
        e.lat = 1;
        if (e.err) return e;
        w = ref_mem[addr[11:2]];
        if (!we) begin
            e.rdata = (w >> sh) & m;
            if (!f3[2] && sz < 4 && e.rdata[8 * sz - 1]) e.rdata = e.rdata | ~m;
            e.nrd = 1;
            e.lat = 2;
        end else begin
            ref_mem[addr[11:2]] = (w & ~(m << sh)) | ((wdata & m) << sh);
            e.nwr = 1;
            e.nrd = sz < 4 ? 1 : 0;
            e.lat = sz < 4 ? 3 : 2;
        end
        return e;
    endfunction

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata, input int hold);
        exp_t e;
        int n;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("req_ready_wait_timeout", 32'(n >= 50), 32'd0);
        bus.req_valid = 1'b1;
        bus.req_we = we;
        bus.req_funct3 = f3;
        bus.req_addr = addr;
        bus.req_wdata = wdata;
        e = model(we, f3, addr, wdata);
        e.acc = cyc + 1;
        q.push_back(e);
        @(posedge clk); #1;
        // Keep req_valid high with scrambled fields while busy: must be ignored
        n = 0;
        while (!bus.resp_valid && n < 10) begin
            bus.req_we = 1'($urandom);
            bus.req_funct3 = 3'($urandom);
            bus.req_addr = $urandom;
            bus.req_wdata = $urandom;
            @(posedge clk); #1;
            n++;
        end
        bus.req_valid = 1'b0;
        chk("resp_valid_timeout", 32'(n >= 10), 32'd0);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        int nrd;
        int nwr;
        int lat;
        logic seen;
        logic [31:0] s_rdata;
        logic s_err;
        nrd = 0;
        nwr = 0;
        lat = 0;
        seen = 1'b0;
        s_rdata = 32'b0;
        s_err = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                nrd = 0;
                nwr = 0;
                seen = 1'b0;
            end else begin
                if (bus.mem_read || bus.mem_write) begin
                    nrd += int'(bus.mem_read);
                    nwr += int'(bus.mem_write);
                    chk("mem_addr", bus.mem_addr, q.size() > 0 ? {q[0].addr[31:2], 2'b00} : 32'hDEAD_BEEF);
                end
                if (bus.resp_valid) begin
                    chk("req_ready_while_resp", 32'(bus.req_ready), 32'd0);
                    if (q.size() == 0) begin
                        chk("unexpected_resp", 32'd1, 32'd0);
                    end else begin
                        if (!seen) begin
                            seen = 1'b1;
                            lat = cyc - q[0].acc + 1;
                            s_rdata = bus.resp_rdata;
                            s_err = bus.resp_err;
                        end else begin
                            chk("stall_rdata_stable", bus.resp_rdata, s_rdata);
                            chk("stall_err_stable", 32'(bus.resp_err), 32'(s_err));
                        end
                        if (bus.resp_ready) begin
                            e = q.pop_front();
                            chk("resp_rdata", bus.resp_rdata, e.rdata);
                            chk("resp_err", 32'(bus.resp_err), 32'(e.err));
                            chk("latency", 32'(lat), 32'(e.lat));
                            chk("mem_read_cycles", 32'(nrd), 32'(e.nrd));
                            chk("mem_write_cycles", 32'(nwr), 32'(e.nwr));
                            seen = 1'b0;
                            nrd = 0;
                            nwr = 0;
                        end
                    end
                end
            end
        end
    end

    initial begin : stimulus
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr = 32'b0;
        bus.req_wdata = 32'b0;
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[1] = 32'h8899AABB;
        ref_mem[1] = 32'h8899AABB;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
        chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        issue(1'b0, 3'b000, 32'h5, 32'h0, 0);
        issue(1'b0, 3'b100, 32'h7, 32'h0, 0);
        issue(1'b0, 3'b001, 32'h6, 32'h0, 0);
        issue(1'b0, 3'b101, 32'h4, 32'h0, 0);
        issue(1'b1, 3'b000, 32'h5, 32'hCAFE_0011, 0);
        chk("sb_merged_word", mem[1], 32'h889911BB);
        issue(1'b0, 3'b010, 32'h4, 32'h0, 0);
        issue(1'b1, 3'b001, 32'h3, 32'h1234, 1);
        issue(1'b0, 3'b010, 32'h2, 32'h0, 0);
        issue(1'b0, 3'b011, 32'h0, 32'h0, 0);
        issue(1'b1, 3'b100, 32'h8, 32'h0, 0);
        issue(1'b0, 3'b010, 32'h1000, 32'h0, 0);
        issue(1'b1, 3'b010, 32'hFFFF_FFFC, 32'h0, 0);
        issue(1'b0, 3'b010, 32'h4, 32'h0, 5);

        // Reset while a SW sits in WR: the write must be abandoned
        bus.req_valid = 1'b1;
        bus.req_we = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr = 32'h10;
        bus.req_wdata = ~mem[4];
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("sw_in_wr_mem_write", 32'(bus.mem_write), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_mem_write", 32'(bus.mem_write), 32'd0);
        chk("abort_req_ready", 32'(bus.req_ready), 32'd1);
        chk("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        issue(1'b0, 3'b010, 32'h10, 32'h0, 0);

        for (int i = 0; i < 150; i++) begin
            we = 1'($urandom);
            a = $urandom_range(0, 9) == 0 ? $urandom : 32'($urandom_range(0, 63));
            f3 = 3'($urandom_range(0, 2));
            if (!we && $urandom_range(0, 1) == 1) f3[2] = 1'b1;
            if ($urandom_range(0, 5) == 0) f3 = 3'($urandom);
            issue(we, f3, a, $urandom, $urandom_range(0, 2));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
